// File: rtl/decoder_stream.sv
// decoder_stream: buffers binary index codes in a small FIFO and re-expands
// them into registered one-hot vectors, with valid/ready on both sides.
// Codes that do not map onto an output line are dropped and counted.
module decoder_stream #(
    parameter int OUT_WIDTH  = 8,
    parameter int IN_WIDTH   = $clog2(OUT_WIDTH),
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IN_WIDTH-1:0]  in_code,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] out,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 clear_err,
    output logic                 err,
    output logic [7:0]           drop_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]     DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [OUT_WIDTH-1:0] ONE_HOT0  = OUT_WIDTH'(1);

    logic [IN_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    fifo_count;

    logic                 in_range;
    logic                 accept;
    logic                 push;
    logic                 drop;
    logic                 pop;
    logic                 fifo_empty;
    logic [IN_WIDTH-1:0]  head_code;
    logic [OUT_WIDTH-1:0] decoded;

    // When every code value names an output line there is nothing to range-check.
    generate
        if (OUT_WIDTH == (1 << IN_WIDTH)) begin : g_full_range
            assign in_range = 1'b1;
        end else begin : g_partial_range
            localparam logic [IN_WIDTH:0] CODE_LIMIT = (IN_WIDTH + 1)'(OUT_WIDTH);
            assign in_range = {1'b0, in_code} < CODE_LIMIT;
        end
    endgenerate

    // in_ready looks only at the registered occupancy, so a pop in this cycle
    // frees its slot one cycle later and out_ready never reaches in_ready.
    assign in_ready   = fifo_count < DEPTH_CNT;
    assign fifo_empty = fifo_count == '0;

    assign accept = in_valid && in_ready;
    assign push   = accept && in_range;
    assign drop   = accept && !in_range;

    // The output register refills whenever it is empty or being consumed.
    assign pop = !fifo_empty && (!out_valid || out_ready);

    assign head_code = fifo_mem[rd_ptr];
    assign decoded   = ONE_HOT0 << head_code;

    // Code storage; contents are don't-care until written, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_code;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Output register: load the decoded head, or go idle once the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else if (pop) begin
            out       <= decoded;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out       <= '0;
            out_valid <= 1'b0;
        end
    end

    // Drop bookkeeping; a drop coinciding with clear_err restarts the count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err      <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            err <= 1'b1;
            if (clear_err) begin
                drop_cnt <= 8'd1;
            end else if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end else if (clear_err) begin
            err      <= 1'b0;
            drop_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_decoder_stream.sv
// tb_decoder_stream: drives an 8-line and a 6-line decoder from the same
// stimulus and compares both against a queue-level model every cycle.
module tb_decoder_stream;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] in_code = '0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       clear_err = 1'b0;

    logic       ir8, ov8, err8;
    logic [7:0] out8, dc8;
    logic       ir6, ov6, err6;
    logic [5:0] out6;
    logic [7:0] dc6;

    int total = 0;
    int bad   = 0;

    // posedge snapshot of the inputs the DUTs saw
    logic       s_live = 1'b0;
    logic       s_valid = 1'b0;
    logic [2:0] s_code = '0;
    logic       s_ready = 1'b0;
    logic       s_clear = 1'b0;

    // model: per instance, circular code buffer plus output register
    int mbuf [2][64];
    int mhead [2];
    int mlen [2];
    int mov [2];
    int mcode [2];
    int merr [2];
    int mcnt [2];

    logic [7:0] cap [12];
    int         got [$];
    int         bp_codes [6];
    bit         sent;

    always #5 clk = ~clk;

    decoder_stream #(.OUT_WIDTH(8), .FIFO_DEPTH(DEPTH)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_code(in_code), .in_valid(in_valid),
        .in_ready(ir8), .out(out8), .out_valid(ov8), .out_ready(out_ready),
        .clear_err(clear_err), .err(err8), .drop_cnt(dc8)
    );

    decoder_stream #(.OUT_WIDTH(6), .FIFO_DEPTH(DEPTH)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .in_code(in_code), .in_valid(in_valid),
        .in_ready(ir6), .out(out6), .out_valid(ov6), .out_ready(out_ready),
        .clear_err(clear_err), .err(err6), .drop_cnt(dc6)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h want=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] c,
                                 input logic r, input logic clr);
        in_valid  = v;
        in_code   = c;
        out_ready = r;
        clear_err = clr;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mhead[k] = 0;
            mlen[k]  = 0;
            mov[k]   = 0;
            mcode[k] = 0;
            merr[k]  = 0;
            mcnt[k]  = 0;
        end
    endtask

    // One clock of behaviour: at most one pop into the output slot, one push,
    // and drop accounting for codes beyond the line count.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int w;
            bit acc;
            bit rng;
            bit pp;
            w   = (k == 0) ? 8 : 6;
            acc = s_valid && (mlen[k] < DEPTH);
            rng = int'(s_code) < w;
            pp  = (mlen[k] > 0) && ((mov[k] == 0) || s_ready);
            if (pp) begin
                mcode[k] = mbuf[k][mhead[k] % 64];
                mhead[k]++;
                mlen[k]--;
                mov[k] = 1;
            end else if (s_ready) begin
                mov[k] = 0;
            end
            if (acc && rng) begin
                mbuf[k][(mhead[k] + mlen[k]) % 64] = int'(s_code);
                mlen[k]++;
            end
            if (acc && !rng) begin
                merr[k] = 1;
                mcnt[k] = s_clear ? 1 : ((mcnt[k] < 255) ? mcnt[k] + 1 : 255);
            end else if (s_clear) begin
                merr[k] = 0;
                mcnt[k] = 0;
            end
        end
    endtask

    always @(posedge clk) begin
        s_live  <= rst_n;
        s_valid <= in_valid;
        s_code  <= in_code;
        s_ready <= out_ready;
        s_clear <= clear_err;
    end

    // Compare process: advance the model, then check both DUTs on every negedge.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_reset();
            end else if (s_live) begin
                model_step();
            end
            for (int k = 0; k < 2; k++) begin
                logic [31:0] a_out, a_ir, a_ov, a_err, a_dc, e_out;
                a_out = (k == 0) ? 32'(out8) : 32'(out6);
                a_ir  = (k == 0) ? 32'(ir8)  : 32'(ir6);
                a_ov  = (k == 0) ? 32'(ov8)  : 32'(ov6);
                a_err = (k == 0) ? 32'(err8) : 32'(err6);
                a_dc  = (k == 0) ? 32'(dc8)  : 32'(dc6);
                e_out = (mov[k] != 0) ? (32'd1 << mcode[k]) : 32'd0;
                checkOutput($sformatf("model_out[%0d]", k), a_out, e_out);
                checkOutput($sformatf("model_out_valid[%0d]", k), a_ov, 32'(mov[k]));
                checkOutput($sformatf("model_in_ready[%0d]", k), a_ir, 32'(mlen[k] < DEPTH));
                checkOutput($sformatf("model_err[%0d]", k), a_err, 32'(merr[k]));
                checkOutput($sformatf("model_drop_cnt[%0d]", k), a_dc, 32'(mcnt[k]));
                checkOutput($sformatf("onehot0[%0d]", k), 32'($onehot0(a_out)), 32'd1);
                checkOutput($sformatf("nonzero_vs_valid[%0d]", k), 32'(a_out != 0), a_ov);
            end
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got=timeout want=finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $finish;
    end

    initial begin
        bp_codes = '{3, 1, 6, 2, 7, 0};

        // reset state
        applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_in_ready", 32'(ir8), 32'd1);
        checkOutput("rst_out_valid", 32'(ov8), 32'd0);
        checkOutput("rst_out", 32'(out8), 32'd0);
        checkOutput("rst_err", 32'(err8), 32'd0);
        checkOutput("rst_drop_cnt", 32'(dc8), 32'd0);

        // single code 5: visible two cycles after in_valid, for exactly one cycle
        applyStimulus(1'b1, 3'd5, 1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
        checkOutput("single_not_yet", 32'(ov8), 32'd0);
        checkOutput("single_in_ready", 32'(ir8), 32'd1);
        @(negedge clk);
        checkOutput("single_out", 32'(out8), 32'h20);
        checkOutput("single_valid", 32'(ov8), 32'd1);
        @(negedge clk);
        checkOutput("single_one_cycle", 32'(ov8), 32'd0);

        // sweep 0..7 back to back
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            cap[c] = out8;
            if (c < 8) applyStimulus(1'b1, 3'(c), 1'b1, 1'b0);
            else       applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
        end
        checkOutput("sweep_idle_before", 32'(cap[1]), 32'd0);
        for (int c = 0; c < 8; c++) begin
            checkOutput($sformatf("sweep_%0d", c), 32'(cap[c + 2]), 32'd1 << c);
        end

        // backpressure: five codes fill FIFO plus output register
        @(negedge clk);
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput($sformatf("bp_ready_%0d", k), 32'(ir8), 32'd1);
            applyStimulus(1'b1, 3'(bp_codes[k]), 1'b0, 1'b0);
        end
        @(negedge clk);
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
        checkOutput("bp_full", 32'(ir8), 32'd0);
        @(negedge clk);
        checkOutput("bp_hold_out", 32'(out8), 32'h08);
        checkOutput("bp_hold_full", 32'(ir8), 32'd0);
        got.delete();
        if (ov8) got.push_back(int'(out8));
        sent = 1'b0;
        applyStimulus(1'b1, 3'(bp_codes[5]), 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ov8) got.push_back(int'(out8));
            if (sent) applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
            else if (ir8 && in_valid) sent = 1'b1;
        end
        checkOutput("bp_count", 32'(got.size()), 32'd6);
        for (int k = 0; k < 6; k++) begin
            checkOutput($sformatf("bp_order_%0d", k),
                        (k < got.size()) ? 32'(got[k]) : 32'hDEAD, 32'd1 << bp_codes[k]);
        end

        // out-of-range codes on the 6-line instance
        applyStimulus(1'b0, 3'd0, 1'b1, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("clear_err6", 32'(err6), 32'd0);
        checkOutput("clear_cnt6", 32'(dc6), 32'd0);
        applyStimulus(1'b1, 3'd7, 1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 3'd2, 1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
        got.delete();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ov6) got.push_back(int'(out6));
        end
        checkOutput("oor_count", 32'(got.size()), 32'd1);
        checkOutput("oor_out", (got.size() > 0) ? 32'(got[0]) : 32'hDEAD, 32'b000100);
        checkOutput("oor_err", 32'(err6), 32'd1);
        checkOutput("oor_drop_cnt", 32'(dc6), 32'd1);

        // saturation at 255
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b1, 3'd7, 1'b1, 1'b0);
            @(negedge clk);
        end
        applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("sat_drop_cnt", 32'(dc6), 32'd255);
        checkOutput("sat_err", 32'(err6), 32'd1);

        // clear coincident with a drop
        applyStimulus(1'b1, 3'd6, 1'b1, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
        checkOutput("clr_drop_err", 32'(err6), 32'd1);
        checkOutput("clr_drop_cnt", 32'(dc6), 32'd1);

        // reset mid-stream: output holds 1, FIFO holds 2,3,5
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, (k == 3) ? 3'd5 : 3'(k + 1), 1'b0, 1'b0);
            @(negedge clk);
        end
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("pre_rst_out", 32'(out8), 32'h02);
        checkOutput("pre_rst_valid", 32'(ov8), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_out", 32'(out8), 32'd0);
        checkOutput("async_rst_valid", 32'(ov8), 32'd0);
        checkOutput("async_rst_ready", 32'(ir8), 32'd1);
        checkOutput("async_rst_valid6", 32'(ov6), 32'd0);
        checkOutput("async_rst_cnt6", 32'(dc6), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1'b1, 3'd4, 1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
        got.delete();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ov8) got.push_back(int'(out8));
        end
        checkOutput("post_rst_count", 32'(got.size()), 32'd1);
        checkOutput("post_rst_out", (got.size() > 0) ? 32'(got[0]) : 32'hDEAD, 32'h10);

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
            @(negedge clk);
        end
        applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
